// File: rtl/lazer_pkg.sv
// Shared constants and types for the laser fire-control slice.
package lazer_pkg;

  localparam int unsigned COORD_W        = 11;
  localparam int unsigned Y_MIN          = 247;
  localparam int unsigned PARK_X         = 1050;
  localparam int unsigned PARK_Y         = 128;
  localparam int unsigned NUM_LAZERS_DEF = 4;

  typedef enum logic {SCHED_IDLE, SCHED_COOL} sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-free finder: searches upward from ptr, wrapping.
module rr_pick
  import lazer_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    free,
  input  logic [IdxW-1:0] ptr,
  output logic            found,
  output logic [IdxW-1:0] idx
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest free slot wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    j     = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IdxW+1)'(i);
      if (sum >= (IdxW+1)'(N)) sum = sum - (IdxW+1)'(N);
      j = sum[IdxW-1:0];
      if (free[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/lazer_scheduler.sv
// Fire-control scheduler: allocates laser mover slots round-robin on button presses,
// enforces a refire cooldown and mirrors each mover's retire rule into a busy map.
module lazer_scheduler #(
  parameter int unsigned NUM_LAZERS     = lazer_pkg::NUM_LAZERS_DEF,
  parameter int unsigned COOLDOWN_TICKS = 6,
  parameter int unsigned Y_MIN          = lazer_pkg::Y_MIN,
  parameter int unsigned COORD_W        = lazer_pkg::COORD_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          move,
  input  logic                          fire_btn,
  input  logic [NUM_LAZERS*COORD_W-1:0] slot_y,
  input  logic [NUM_LAZERS-1:0]         slot_hit,
  output logic [NUM_LAZERS-1:0]         fire,
  output logic [NUM_LAZERS-1:0]         busy,
  output logic                          cooling,
  output logic                          dropped,
  output logic [15:0]                   shots
);
  import lazer_pkg::*;

  localparam int unsigned PtrW = $clog2(NUM_LAZERS);
  localparam int unsigned CdW  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  sched_state_e          state_q;
  logic                  btn_q;
  logic [PtrW-1:0]       rr_ptr_q;
  logic [CdW-1:0]        cd_cnt_q;
  logic [NUM_LAZERS-1:0] fire_q, busy_q;
  logic                  dropped_q;
  logic [15:0]           shots_q;

  logic                  rise, grant, pick_found;
  logic [PtrW-1:0]       pick_idx, ptr_next;
  logic [NUM_LAZERS-1:0] free_mask, grant_vec, retire;

  assign free_mask = ~busy_q;

  rr_pick #(
    .N(NUM_LAZERS)
  ) u_pick (
    .free  (free_mask),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    rise      = fire_btn & ~btn_q;
    grant     = rise & en & (state_q == SCHED_IDLE) & pick_found;
    grant_vec = grant ? (NUM_LAZERS'(1) << pick_idx) : '0;
    ptr_next  = (pick_idx == PtrW'(NUM_LAZERS - 1)) ? '0 : pick_idx + PtrW'(1);
    // The fire-cycle mover is still parked below Y_MIN, so ~fire_q guards a false retire.
    retire = '0;
    for (int i = 0; i < int'(NUM_LAZERS); i++) begin
      retire[i] = move & busy_q[i] & ~fire_q[i] &
                  (slot_hit[i] | (slot_y[i*COORD_W +: COORD_W] < COORD_W'(Y_MIN)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCHED_IDLE;
      btn_q     <= 1'b1;
      rr_ptr_q  <= '0;
      cd_cnt_q  <= '0;
      fire_q    <= '0;
      busy_q    <= '0;
      dropped_q <= 1'b0;
      shots_q   <= '0;
    end else begin
      btn_q     <= fire_btn;
      fire_q    <= grant_vec;
      dropped_q <= rise & ~grant;
      busy_q    <= (busy_q & ~retire) | grant_vec;
      if (grant) begin
        rr_ptr_q <= ptr_next;
        shots_q  <= shots_q + 16'd1;
      end
      if (!en) begin
        state_q  <= SCHED_IDLE;
        cd_cnt_q <= '0;
      end else begin
        case (state_q)
          SCHED_IDLE: begin
            if (grant) begin
              state_q  <= SCHED_COOL;
              cd_cnt_q <= CdW'(COOLDOWN_TICKS);
            end
          end
          SCHED_COOL: begin
            if (cd_cnt_q == '0) state_q <= SCHED_IDLE;
            else if (move)      cd_cnt_q <= cd_cnt_q - CdW'(1);
          end
          default: state_q <= SCHED_IDLE;
        endcase
      end
    end
  end

  assign fire    = fire_q;
  assign busy    = busy_q;
  assign cooling = (state_q == SCHED_COOL);
  assign dropped = dropped_q;
  assign shots   = shots_q;

endmodule

// File: tb/tb_lazer_scheduler.sv
// Scoreboard bench for lazer_scheduler: dut_a uses a 2-tick cooldown, dut_b a zero cooldown.
module tb_lazer_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        move = 1'b0;
  logic        fire_btn_a = 1'b1;
  logic        fire_btn_b = 1'b0;
  logic [43:0] slot_y = {4{11'd300}};
  logic [3:0]  slot_hit = 4'b0000;

  logic [3:0]  fire_a, busy_a, fire_b, busy_b;
  logic        cooling_a, dropped_a, cooling_b, dropped_b;
  logic [15:0] shots_a, shots_b;

  int checks = 0;
  int errors = 0;

  logic [4:0] q_a[$];
  logic [4:0] q_b[$];
  logic [4:0] e_a, e_b;

  always #5 clk = ~clk;

  lazer_scheduler #(
    .NUM_LAZERS(4), .COOLDOWN_TICKS(2), .Y_MIN(247), .COORD_W(11)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .move(move), .fire_btn(fire_btn_a),
    .slot_y(slot_y), .slot_hit(slot_hit), .fire(fire_a), .busy(busy_a),
    .cooling(cooling_a), .dropped(dropped_a), .shots(shots_a)
  );

  lazer_scheduler #(
    .NUM_LAZERS(4), .COOLDOWN_TICKS(0), .Y_MIN(247), .COORD_W(11)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .move(move), .fire_btn(fire_btn_b),
    .slot_y(slot_y), .slot_hit(slot_hit), .fire(fire_b), .busy(busy_b),
    .cooling(cooling_b), .dropped(dropped_b), .shots(shots_b)
  );

  // Monitors: every fire or dropped pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && (fire_a != 4'b0000 || dropped_a)) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL mon_a unexpected: got fire=%b dropped=%b, want no event", fire_a, dropped_a);
      end else begin
        e_a = q_a.pop_front();
        if ({fire_a, dropped_a} !== e_a) begin
          errors++;
          $display("FAIL mon_a event: got fire=%b dropped=%b, want fire=%b dropped=%b",
                   fire_a, dropped_a, e_a[4:1], e_a[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (fire_b != 4'b0000 || dropped_b)) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL mon_b unexpected: got fire=%b dropped=%b, want no event", fire_b, dropped_b);
      end else begin
        e_b = q_b.pop_front();
        if ({fire_b, dropped_b} !== e_b) begin
          errors++;
          $display("FAIL mon_b event: got fire=%b dropped=%b, want fire=%b dropped=%b",
                   fire_b, dropped_b, e_b[4:1], e_b[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic press(input bit on_b, input logic [3:0] exp_fire, input logic exp_drop);
    if (on_b) q_b.push_back({exp_fire, exp_drop});
    else      q_a.push_back({exp_fire, exp_drop});
    @(negedge clk);
    if (on_b) fire_btn_b = 1'b1;
    else      fire_btn_a = 1'b1;
    @(negedge clk);
    fire_btn_a = 1'b0;
    fire_btn_b = 1'b0;
  endtask

  task automatic pulse_move();
    @(negedge clk); move = 1'b1;
    @(negedge clk); move = 1'b0;
  endtask

  task automatic set_y(input int s, input int v);
    slot_y[s*11 +: 11] = v[10:0];
  endtask

  initial begin
    // Button held through reset must not fire.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_fire_a", {12'd0, fire_a}, 16'h0000);
    chk("rst_shots_a", shots_a, 16'h0000);
    chk("rst_busy_a", {12'd0, busy_a}, 16'h0000);
    chk("rst_cooling_a", {15'd0, cooling_a}, 16'h0000);
    chk("rst_shots_b", shots_b, 16'h0000);
    chk("rst_busy_b", {12'd0, busy_b}, 16'h0000);
    fire_btn_a = 1'b0;
    press(1'b0, 4'b0001, 1'b0);
    chk("first_shots_a", shots_a, 16'd1);
    chk("first_busy_a", {12'd0, busy_a}, 16'h0001);
    chk("first_cooling_a", {15'd0, cooling_a}, 16'h0001);

    // Cooldown of 2 ticks: press after one move is dropped.
    pulse_move();
    press(1'b0, 4'b0000, 1'b1);
    chk("cool_hold_a", {15'd0, cooling_a}, 16'h0001);
    chk("cool_shots_a", shots_a, 16'd1);
    pulse_move();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!cooling_a) break;
    end
    chk("cool_fall_a", {15'd0, cooling_a}, 16'h0000);
    press(1'b0, 4'b0010, 1'b0);
    chk("second_shots_a", shots_a, 16'd2);
    chk("second_busy_a", {12'd0, busy_a}, 16'h0003);

    // Fire-cycle guard on dut_b: parked y=128 with move during the fire pulse.
    q_b.push_back({4'b0001, 1'b0});
    @(negedge clk); fire_btn_b = 1'b1;
    @(negedge clk); fire_btn_b = 1'b0; set_y(0, 128); move = 1'b1;
    @(negedge clk); move = 1'b0; set_y(0, 300);
    chk("fire_guard_busy_b", {12'd0, busy_b}, 16'h0001);
    chk("fire_guard_shots_b", shots_b, 16'd1);

    // Pool fills with zero cooldown, then the fifth press is dropped.
    press(1'b1, 4'b0010, 1'b0);
    press(1'b1, 4'b0100, 1'b0);
    press(1'b1, 4'b1000, 1'b0);
    press(1'b1, 4'b0000, 1'b1);
    chk("full_busy_b", {12'd0, busy_b}, 16'h000f);
    chk("full_shots_b", shots_b, 16'd4);

    // Retire threshold: y == Y_MIN holds, y == Y_MIN-1 retires.
    set_y(1, 247);
    pulse_move();
    chk("y247_holds_b", {12'd0, busy_b}, 16'h000f);
    set_y(1, 246);
    pulse_move();
    chk("y246_retires_b", {12'd0, busy_b}, 16'h000d);
    set_y(1, 300);
    set_y(3, 100);
    pulse_move();
    set_y(3, 300);
    chk("y100_retires_b", {12'd0, busy_b}, 16'h0005);
    press(1'b1, 4'b0010, 1'b0);
    chk("refill1_busy_b", {12'd0, busy_b}, 16'h0007);

    // Collision on slot 2 on the same edge as the grant to slot 3.
    q_b.push_back({4'b1000, 1'b0});
    @(negedge clk); fire_btn_b = 1'b1; move = 1'b1; slot_hit = 4'b0100;
    @(negedge clk); fire_btn_b = 1'b0; move = 1'b0; slot_hit = 4'b0000;
    chk("collide_busy_b", {12'd0, busy_b}, 16'h000b);
    set_y(0, 100);
    pulse_move();
    set_y(0, 300);
    chk("retire0_busy_b", {12'd0, busy_b}, 16'h000a);
    press(1'b1, 4'b0001, 1'b0);
    chk("wrap_busy_b", {12'd0, busy_b}, 16'h000b);
    chk("wrap_shots_b", shots_b, 16'd7);

    // en low: press dropped, FSM idle, busy kept.
    @(negedge clk); en = 1'b0;
    press(1'b1, 4'b0000, 1'b1);
    chk("en_low_cooling_b", {15'd0, cooling_b}, 16'h0000);
    chk("en_low_busy_b", {12'd0, busy_b}, 16'h000b);
    chk("en_low_shots_b", shots_b, 16'd7);
    en = 1'b1;
    press(1'b1, 4'b0100, 1'b0);
    chk("last_busy_b", {12'd0, busy_b}, 16'h000f);
    chk("last_shots_b", shots_b, 16'd8);

    repeat (4) @(negedge clk);
    while (q_a.size() > 0) begin
      e_a = q_a.pop_front();
      checks++; errors++;
      $display("FAIL mon_a missing: got no event, want fire=%b dropped=%b", e_a[4:1], e_a[0]);
    end
    while (q_b.size() > 0) begin
      e_b = q_b.pop_front();
      checks++; errors++;
      $display("FAIL mon_b missing: got no event, want fire=%b dropped=%b", e_b[4:1], e_b[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lazer_scheduler.md
# lazer_scheduler

Fire-control controller that shares a pool of `NUM_LAZERS` laser mover instances between the player's fire button and enforces a refire cooldown. It sits between the button input and the movers, tracks which mover slots are in flight, allocates a free slot round-robin on each press, and issues that slot's one-cycle `fire` pulse. It mirrors each mover's retire rule so its busy map matches the movers without extra status ports.

## Interface
- `NUM_LAZERS`, 4: number of mover slots, 2..8.
- `COOLDOWN_TICKS`, 6: `move` ticks after a grant before the next press is accepted; 0 is legal.
- `Y_MIN`, 247: retire threshold; must equal the movers' value.
- `COORD_W`, 11: coordinate width.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  game running; low blocks grants.
- `move`  in  1  frame tick, the same signal that drives the movers.
- `fire_btn`  in  1  fire button level, already synchronised to `clk`.
- `slot_y`  in  `NUM_LAZERS*COORD_W`  per-slot mover `oy`; slot i is at bits [i*COORD_W +: COORD_W].
- `slot_hit`  in  `NUM_LAZERS`  per-slot collision, the same signal that drives each mover.
- `fire`  out  `NUM_LAZERS`  one-hot, one-cycle fire pulse to the granted mover.
- `busy`  out  `NUM_LAZERS`  slot in flight.
- `cooling`  out  1  high while in COOL.
- `dropped`  out  1  one-cycle pulse when a press is rejected.
- `shots`  out  16  count of granted shots; wraps.

## Operation
- Press detection: `rise = fire_btn & ~btn_q`. `btn_q` resets to 1, so a button held through reset never fires.
- FSM states: IDLE, COOL.
- **IDLE:** on `rise & en`:
  - If any slot is free (`busy == 0` for that slot), grant it:
    - Pick the first free slot searching upward from `rr_ptr`, wrapping.
    - Register `fire[g]=1`, set `busy[g]`, `rr_ptr <= (g+1) mod NUM_LAZERS`, `shots <= shots+1`.
    - Load `cd_cnt <= COOLDOWN_TICKS` and go to COOL.
  - If no slot is free: `dropped=1` for one cycle, stay in IDLE.
- **COOL:**
  - Each `move` decrements `cd_cnt`.
  - Go to IDLE on the edge where `cd_cnt==0` is observed, and never in the same cycle as a grant.
  - With `COOLDOWN_TICKS=0`, COOL lasts exactly one cycle.
  - A `rise` while in COOL gives `dropped=1`.
- **`en` low:**
  - A `rise` gives `dropped=1`.
  - The FSM is forced to IDLE and `cd_cnt` is cleared.
  - Busy tracking continues.
- **Retire:** `busy[i]` clears on the edge where `move & busy[i] & ~fire[i] & (slot_hit[i] | slot_y[i] < Y_MIN)`.
  - The comparison is unsigned, `COORD_W` bits, and uses the pre-decrement `oy`, exactly as the mover does.
  - The `~fire[i]` term is required. During the fire-pulse cycle the mover is still parked at y=128, which is below `Y_MIN` and would otherwise retire the slot falsely.
- **Simultaneous events:**
  - A grant and a retire of different slots on the same edge are both applied.
  - A slot that retires on edge k is grantable from edge k+1.
- `shots` wraps from 0xFFFF to 0.

## Timing
- `rise` visible in cycle k → `fire[g]`, `busy[g]` and `cooling` go high at edge k+1.
- `fire` stays high exactly one cycle. The mover latches at edge k+2.
- `dropped` goes high at edge k+1 for one cycle.
- Reset values (asynchronous):
  - `fire=0`, `busy=0`, `cooling=0`, `dropped=0`, `shots=0`.
  - State IDLE, `rr_ptr=0`, `cd_cnt=0`, `btn_q=1`.
- Reset mid-flight clears `busy`. The movers share `rst` and return to their parked state, so the two stay consistent.

## Structure
- Package `lazer_pkg` holds:
  - `COORD_W`, `Y_MIN`, and the parked coordinates x=1050, y=128.
  - Default `NUM_LAZERS`.
  - State enum `{SCHED_IDLE, SCHED_COOL}`.
- Sub-module `rr_pick`: combinational round-robin first-free finder.
  - Inputs: `free` mask and `ptr`.
  - Outputs: `found` and `idx`.
  - Reused later for enemy bullet pools.

## Test plan
- **Reset with button held:** hold `fire_btn=1` through reset release. Expect no `fire` and `shots=0`. Release, then press: `fire=4'b0001` and `shots=1`.
- **Cooldown:**
  - Stimulus: `COOLDOWN_TICKS=2`; press, then press again before the 2nd `move`.
  - Expect: second press gives `dropped=1`. A press after `cooling` falls gives `fire=4'b0010`.
- **Pool full:**
  - Stimulus: `COOLDOWN_TICKS=0`; 4 presses with no retire.
  - Expect: grants 0001, 0010, 0100, 1000. 5th press gives `dropped=1` and `busy=4'b1111`.
- **Retire by y:**
  - Stimulus: slot 1 busy, `slot_y[1]=246`, `move`.
  - Expect: `busy[1]` clears.
  - Stimulus: `slot_y=247`.
  - Expect: `busy[1]` stays set.
- **Fire-cycle guard:** during the `fire[0]` cycle, with `slot_y[0]=128` and `move=1`, `busy[0]` stays set.
- **Collision during grant:**
  - Stimulus: `slot_hit[2]` with `move` on the same edge as a grant to slot 3.
  - Expect: `busy[2]` clears, `busy[3]` sets, and the next grant searches from slot 0.
